// File: rtl/condflow_pkg.sv
// condflow_pkg: shared FSM state type and route-select constants for condflow elements.
//   split_state_t : IDLE (wait for both channels), REQ (output request raised),
//                   ACK (input acks raised, wait for return-to-zero)
//   SEL_OUT0/1    : values of the route-select bit for output 0 / output 1
package condflow_pkg;
  typedef enum logic [1:0] {IDLE, REQ, ACK} split_state_t;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/split_sync2_sync_ff.sv
// sync_ff: 1-bit multi-flop synchroniser, asynchronous reset to 0.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronised output, STAGES clock edges after d settles
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], d};
  end
  assign q = r_chain[STAGES-1];
endmodule

// File: rtl/split_sync2.sv
// split_sync2: clocked two-way conditional split of a 4-phase bundled-data token, routed by a control bit.
//   clk     : single clock, rising edge
//   rst     : asynchronous active-high reset
//   r_i/a_i/d_i          : data input channel (request, acknowledge, bundled data)
//   rctl_i/dctl_i/actl_i : control channel (request, route select, acknowledge)
//   r0_o/a0_o/d0_o       : output channel 0
//   r1_o/a1_o/d1_o       : output channel 1
// All outputs come straight from flops; requests and acks are synchronised before use.
module split_sync2
  import condflow_pkg::*;
#(
  parameter int N    = 1,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         rctl_i,
  input  logic         dctl_i,
  output logic         actl_i,
  output logic         r0_o,
  input  logic         a0_o,
  output logic [N-1:0] d0_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o
);
  split_state_t r_state, w_state_nx;
  logic         r_sel, w_sel_nx;
  logic         r_ack, w_ack_nx;
  logic         r_r0, w_r0_nx;
  logic         r_r1, w_r1_nx;
  logic [N-1:0] r_d0, r_d1;
  logic         w_ld0, w_ld1;
  logic         w_rs, w_rcs, w_as0, w_as1, w_as_sel;

  sync_ff #(.STAGES(SYNC)) u_sync_r   (.clk(clk), .rst(rst), .d(r_i),    .q(w_rs));
  sync_ff #(.STAGES(SYNC)) u_sync_rc  (.clk(clk), .rst(rst), .d(rctl_i), .q(w_rcs));
  sync_ff #(.STAGES(SYNC)) u_sync_a0  (.clk(clk), .rst(rst), .d(a0_o),   .q(w_as0));
  sync_ff #(.STAGES(SYNC)) u_sync_a1  (.clk(clk), .rst(rst), .d(a1_o),   .q(w_as1));

  // Only the selected output's ack matters; the other one is ignored in every state.
  assign w_as_sel = (r_sel == SEL_OUT1) ? w_as1 : w_as0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= SEL_OUT0;
      r_ack   <= 1'b0;
      r_r0    <= 1'b0;
      r_r1    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_ack   <= w_ack_nx;
      r_r0    <= w_r0_nx;
      r_r1    <= w_r1_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d0 <= '0;
      r_d1 <= '0;
    end else begin
      if (w_ld0) r_d0 <= d_i;
      if (w_ld1) r_d1 <= d_i;
    end
  end

  // d_i/dctl_i are taken raw: the bundling constraint makes them stable
  // by the time the synchronised requests are both seen.
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_ack_nx   = r_ack;
    w_r0_nx    = r_r0;
    w_r1_nx    = r_r1;
    w_ld0      = 1'b0;
    w_ld1      = 1'b0;
    unique case (r_state)
      IDLE: if (w_rs && w_rcs) begin
        w_sel_nx   = dctl_i;
        w_ld0      = (dctl_i == SEL_OUT0);
        w_ld1      = (dctl_i == SEL_OUT1);
        w_r0_nx    = (dctl_i == SEL_OUT0);
        w_r1_nx    = (dctl_i == SEL_OUT1);
        w_state_nx = REQ;
      end
      REQ: if (w_as_sel) begin
        w_r0_nx    = 1'b0;
        w_r1_nx    = 1'b0;
        w_ack_nx   = 1'b1;
        w_state_nx = ACK;
      end
      ACK: if (!w_rs && !w_rcs && !w_as_sel) begin
        w_ack_nx   = 1'b0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign a_i    = r_ack;
  assign actl_i = r_ack;
  assign r0_o   = r_r0;
  assign r1_o   = r_r1;
  assign d0_o   = r_d0;
  assign d1_o   = r_d1;
endmodule
